// File: rtl/mux15_rr_scheduler_if.sv
// rtl/mux15_rr_scheduler_if.sv - request/select bus between requesters, scheduler and the 15-to-1 mux
interface mux15_rr_scheduler_if #(
  parameter int N_REQ = 15,
  parameter int SEL_W = 4
) ();
  logic [N_REQ-1:0] req;
  logic [SEL_W-1:0] sel;
  logic [N_REQ-1:0] grant;
  logic             valid;
  logic             last;

  modport master (
    input  req,
    output sel,
    output grant,
    output valid,
    output last
  );

  modport slave (
    output req,
    input  sel,
    input  grant,
    input  valid,
    input  last
  );
endinterface

// File: rtl/mux15_rr_scheduler.sv
// rtl/mux15_rr_scheduler.sv - non-preemptive round-robin scheduler driving the 15-to-1 mux select
module mux15_rr_scheduler #(
  parameter int N_REQ       = 15,
  parameter int SEL_W       = 4,
  parameter int HOLD_CYCLES = 3,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mux15_rr_scheduler_if.master    bus
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] win;
  logic             found;
  logic             rearb;

  // Search starts just after the previous winner and wraps modulo N_REQ,
  // so indices >= N_REQ can never be produced.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    rearb = 1'b0;
    case (state)
      IDLE:    rearb = 1'b1;
      HOLD:    rearb = (cnt == '0) && (GAP_CYCLES == 0);
      GAP:     rearb = (cnt == '0);
      default: rearb = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= SEL_W'(N_REQ - 1);
      bus.sel   <= '0;
      bus.grant <= '0;
      bus.valid <= 1'b0;
      bus.last  <= 1'b0;
    end else if (rearb && found) begin
      state     <= HOLD;
      cnt       <= CNT_W'(HOLD_CYCLES - 1);
      ptr       <= win;
      bus.sel   <= win;
      bus.grant <= N_REQ'(1) << win;
      bus.valid <= 1'b1;
      bus.last  <= (HOLD_CYCLES == 1);
    end else begin
      case (state)
        HOLD: begin
          if (cnt != '0) begin
            cnt      <= cnt - 1'b1;
            bus.last <= (cnt == CNT_W'(1));
          end else begin
            state     <= (GAP_CYCLES > 0) ? GAP : IDLE;
            cnt       <= CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
            bus.grant <= '0;
            bus.valid <= 1'b0;
            bus.last  <= 1'b0;
          end
        end
        GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux15_rr_scheduler.sv
// tb/tb_mux15_rr_scheduler.sv - randomized and directed bench for mux15_rr_scheduler against a window-position model
module tb_mux15_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] req_drv = '0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mux15_rr_scheduler_if #(.N_REQ(15), .SEL_W(4)) bus_a ();
  mux15_rr_scheduler_if #(.N_REQ(15), .SEL_W(4)) bus_b ();
  assign bus_a.req = req_drv;
  assign bus_b.req = req_drv;

  mux15_rr_scheduler #(.N_REQ(15), .SEL_W(4), .HOLD_CYCLES(3), .GAP_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  mux15_rr_scheduler #(.N_REQ(15), .SEL_W(4), .HOLD_CYCLES(1), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  // Model: a grant is a window of hold+gap cycles indexed by pos; arbitration
  // happens whenever idle or on the window's final cycle.
  int a_act = 0, a_pos = 0, a_ptr = 14, a_sel = 0;
  int b_act = 0, b_pos = 0, b_ptr = 14, b_sel = 0;

  function automatic int pick(input logic [14:0] r, input int p);
    for (int k = 1; k <= 15; k++) begin
      if (r[(p + k) % 15]) return (p + k) % 15;
    end
    return -1;
  endfunction

  task automatic model_step(input int hold, input int gap, input logic [14:0] r, input logic rn,
                            inout int act, inout int pos, inout int ptr, inout int sel);
    bit opp;
    int w;
    if (!rn) begin
      act = 0; pos = 0; ptr = 14; sel = 0;
    end else begin
      opp = (act == 0) || (pos == hold + gap - 1);
      if (act != 0) pos++;
      if (opp) begin
        w = pick(r, ptr);
        if (w >= 0) begin
          act = 1; pos = 0; ptr = w; sel = w;
        end else begin
          act = 0;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag, input int hold, input int act, input int pos, input int sel,
                             input logic [3:0] o_sel, input logic [14:0] o_grant,
                             input logic o_valid, input logic o_last);
    logic        ev;
    logic [14:0] eg;
    ev = (act != 0) && (pos < hold);
    eg = ev ? (15'(1) << sel) : 15'h0;
    check({tag, ".sel"},   32'(o_sel),   32'(sel));
    check({tag, ".grant"}, 32'(o_grant), 32'(eg));
    check({tag, ".valid"}, 32'(o_valid), 32'(ev));
    check({tag, ".last"},  32'(o_last),  32'(ev && (pos == hold - 1)));
  endtask

  task automatic tick();
    model_step(3, 2, req_drv, rst_n, a_act, a_pos, a_ptr, a_sel);
    model_step(1, 0, req_drv, rst_n, b_act, b_pos, b_ptr, b_sel);
    @(posedge clk);
    @(negedge clk);
    check_model("a", 3, a_act, a_pos, a_sel, bus_a.sel, bus_a.grant, bus_a.valid, bus_a.last);
    check_model("b", 1, b_act, b_pos, b_sel, bus_b.sel, bus_b.grant, bus_b.valid, bus_b.last);
  endtask

  initial begin
    int  ok;
    int  first_v;
    logic [14:0] prev_g;

    // reset state
    rst_n = 1'b0; req_drv = '0;
    tick(); tick();
    check("rst.sel", 32'(bus_a.sel), 32'd0);
    check("rst.valid", 32'(bus_a.valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // single request: 3 valid + 2 gap, period 5
    req_drv = 15'h0004;
    first_v = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (i < 3) check("single.grant", 32'(bus_a.grant), 32'h0004);
      if (i == 2) check("single.last", 32'(bus_a.last), 32'd1);
      if (i == 3 || i == 4) check("single.gap", 32'(bus_a.valid), 32'd0);
      if (i == 5) check("single.repeat", 32'(bus_a.grant), 32'h0004);
    end

    // full rotation from a fresh pointer
    rst_n = 1'b0; req_drv = 15'h7FFF; tick(); rst_n = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (i % 5 == 0) check("rot.sel", 32'(bus_a.sel), 32'((i / 5) % 15));
      check("rot.sel_range", 32'(bus_a.sel < 4'd15), 32'd1);
    end

    // wrap and skip
    rst_n = 1'b0; req_drv = 15'h4001; tick(); rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i % 5 == 0) check("wrap.sel", 32'(bus_a.sel), ((i / 5) % 2 == 0) ? 32'd0 : 32'd14);
    end

    // non-preemption: drop req[2] after its first grant cycle
    req_drv = 15'h0024;
    ok = 0;
    for (int i = 0; i < 30 && ok == 0; i++) begin
      tick();
      if (a_act != 0 && a_pos == 0 && a_sel == 2) ok = 1;
    end
    check("np.found", 32'(ok), 32'd1);
    req_drv = 15'h0020;
    tick(); check("np.hold2", 32'(bus_a.grant), 32'h0004);
    tick(); check("np.hold3", 32'(bus_a.grant), 32'h0004);
    tick(); check("np.gap1", 32'(bus_a.valid), 32'd0);
    tick(); check("np.gap2", 32'(bus_a.valid), 32'd0);
    tick(); check("np.next", 32'(bus_a.grant), 32'h0020);

    // reset during the HOLD of index 7
    req_drv = 15'h7FFF;
    ok = 0;
    for (int i = 0; i < 100 && ok == 0; i++) begin
      tick();
      if (a_act != 0 && a_pos == 1 && a_sel == 7) ok = 1;
    end
    check("mid.found", 32'(ok), 32'd1);
    rst_n = 1'b0; tick();
    check("mid.grant", 32'(bus_a.grant), 32'h0);
    check("mid.last", 32'(bus_a.last), 32'd0);
    rst_n = 1'b1; tick();
    check("mid.first", 32'(bus_a.grant), 32'h0001);

    // back-to-back configuration
    rst_n = 1'b0; req_drv = 15'h0003; tick(); rst_n = 1'b1;
    tick();
    prev_g = bus_b.grant;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("b2b.valid", 32'(bus_b.valid), 32'd1);
      check("b2b.alt", 32'(bus_b.grant), 32'(prev_g ^ 15'h0003));
      prev_g = bus_b.grant;
    end

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       req_drv = '0;
        1:       req_drv = 15'(1) << $urandom_range(0, 14);
        default: req_drv = 15'($urandom);
      endcase
      rst_n = ($urandom_range(0, 59) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
